// File: rtl/i2c_pkg.sv
// Shared I2C constants and the slave byte-transmitter state type.
package i2c_pkg;

  localparam int unsigned BYTE_BITS = 8;

  // Default tHD;DAT in system clocks, common to the master-side blocks.
  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;

  // SDA level seen in the 9th clock.
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLow,
    StHold,
    StWaitRise,
    StWaitFall,
    StAckHold,
    StAckRise,
    StAckFall
  } slv_tx_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for an I2C pin plus a delay stage for edge detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       dly_q;

  // Reset to the idle bus level so no spurious edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      dly_q  <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~dly_q;
  assign fall_o  = ~sync_q[1] & dly_q;

endmodule

// File: rtl/i2c_slave_transmit_byte.sv
// Slave-side byte transmitter: shifts one byte onto open-drain SDA under master SCL,
// then samples the master's ACK/NACK in the 9th clock.
module i2c_slave_transmit_byte
  import i2c_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] data_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       finish,
  output logic       ack,
  output logic       abort
);

  localparam int unsigned BitCntW = $clog2(BYTE_BITS + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_i  (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  slv_tx_state_e      state_q;
  logic [7:0]         shreg_q;
  logic [BitCntW-1:0] bitcnt_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic               sda_oe_q;
  logic               busy_q;
  logic               finish_q;
  logic               ack_q;
  logic               abort_q;

  logic hold_done;
  logic start_stop;

  assign hold_done  = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));
  // Our own SDA changes happen only with SCL low, so any edge with SCL high is the master's.
  assign start_stop = scl_lvl & (sda_rise | sda_fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      hold_cnt_q <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      abort_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            shreg_q    <= data_in;
            bitcnt_q   <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= scl_lvl ? StWaitLow : StHold;
          end
        end
        StWaitLow: begin
          if (scl_fall) begin
            hold_cnt_q <= '0;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (hold_done) begin
            // A 1 bit releases the line; SDA is never driven high.
            sda_oe_q   <= ~shreg_q[7];
            hold_cnt_q <= '0;
            state_q    <= StWaitRise;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        StWaitRise: begin
          if (scl_rise) begin
            if (bitcnt_q != BitCntW'(BYTE_BITS)) begin
              bitcnt_q <= bitcnt_q + BitCntW'(1);
            end
            state_q <= StWaitFall;
          end
        end
        StWaitFall: begin
          if (start_stop) begin
            abort_q  <= 1'b1;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else if (scl_fall) begin
            shreg_q    <= {shreg_q[6:0], 1'b0};
            hold_cnt_q <= '0;
            state_q    <= (bitcnt_q == BitCntW'(BYTE_BITS)) ? StAckHold : StHold;
          end
        end
        StAckHold: begin
          if (hold_done) begin
            sda_oe_q   <= 1'b0;
            hold_cnt_q <= '0;
            state_q    <= StAckRise;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        StAckRise: begin
          if (scl_rise) begin
            ack_q   <= (sda_lvl == SDA_ACK);
            state_q <= StAckFall;
          end
        end
        StAckFall: begin
          if (start_stop) begin
            abort_q  <= 1'b1;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else if (scl_fall) begin
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;
  assign finish = finish_q;
  assign ack    = ack_q;
  assign abort  = abort_q;

endmodule
